// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM between requesters A and B.
// Per-cycle arbitration (round-robin with a BURST_MAX-bounded lock) picks a
// winner, the winning access is registered onto the RAM port, and read data
// is steered back to its owner two cycles after accept.
// Optional build macro: ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
//
// state | meaning
// IDLE  | no access was accepted last cycle
// OWN_A | last accepted access belonged to A
// OWN_B | last accepted access belonged to B

module ram_port_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              lock_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              lock_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;   // 1: B owned the most recent accept
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic              accept_a, accept_b, accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // pipeline tags travelling alongside the access
    logic              p1_rd, p1_b;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

    // arbitration state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // grant decision, accept detection and next-state / burst count
    always_comb begin
        gnt_a       = 1'b0;
        gnt_b       = 1'b0;
        state_d     = IDLE;
        last_b_d    = last_b_q;
        burst_cnt_d = '0;

        if (!rst) begin
`ifdef ARB_FIXED_PRIO_EN
            // A always wins; a B lock can only matter when A is silent
            if (req_a) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
`else
            if (state_q == OWN_A && lock_a && req_a && burst_cnt_q < CNT_MAX) begin
                gnt_a = 1'b1;
            end else if (state_q == OWN_B && lock_b && req_b && burst_cnt_q < CNT_MAX) begin
                gnt_b = 1'b1;
            end else if (req_a && req_b) begin
                // exhausted burst falls here too: the other side wins
                if (last_b_q) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else if (req_a) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
`endif
        end

        accept_a = req_a & gnt_a;
        accept_b = req_b & gnt_b;
        accept   = accept_a | accept_b;

        if (accept_a) begin
            state_d  = OWN_A;
            last_b_d = 1'b0;
            if (state_q != OWN_A || !lock_a) begin
                burst_cnt_d = CNT_ONE;
            end else if (burst_cnt_q == CNT_MAX) begin
                burst_cnt_d = CNT_MAX;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_ONE;
            end
        end else if (accept_b) begin
            state_d  = OWN_B;
            last_b_d = 1'b1;
            if (state_q != OWN_B || !lock_b) begin
                burst_cnt_d = CNT_ONE;
            end else if (burst_cnt_q == CNT_MAX) begin
                burst_cnt_d = CNT_MAX;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_ONE;
            end
        end
    end

    // steer the winner's access fields toward the RAM port registers
    always_comb begin
        sel_we    = we_a;
        sel_addr  = addr_a;
        sel_wdata = wdata_a;
        if (accept_b) begin
            sel_we    = we_b;
            sel_addr  = addr_b;
            sel_wdata = wdata_b;
        end
    end

    // RAM port registers plus the two-stage owner/read tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_di   <= '0;
            p1_rd    <= 1'b0;
            p1_b     <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            ram_en <= accept;
            ram_we <= accept & sel_we;
            if (accept) begin
                ram_addr <= sel_addr;
                ram_di   <= sel_wdata;
            end
            p1_rd    <= accept & ~sel_we;
            p1_b     <= accept_b;
            rvalid_a <= p1_rd & ~p1_b;
            rvalid_b <= p1_rd & p1_b;
        end
    end

    // keep the last delivered read word so rdata stays stable between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (rvalid_a) begin
                rdata_a_q <= ram_do;
            end
            if (rvalid_b) begin
                rdata_b_q <= ram_do;
            end
        end
    end

    // RAM output is only valid in the rvalid cycle, so pass it straight through then
    assign rdata_a = rvalid_a ? ram_do : rdata_a_q;
    assign rdata_b = rvalid_b ? ram_do : rdata_b_q;

endmodule
